// File: rtl/bar1_wr_arbiter.sv
// Round-robin arbiter that shares the single BAR1 register write port
// between three requesters (BAR0 controller, DMA completion, interrupt path).
// A grant issues one write strobe plus ack, then holds until BAR1 finishes
// its read-modify-write or a busy timeout abandons it.
module bar1_wr_arbiter #(
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     wr_en_i,
    input  logic [7*NREQ-1:0]   addr_i,
    input  logic [4*NREQ-1:0]   be_i,
    input  logic [32*NREQ-1:0]  d_i,
    output logic [NREQ-1:0]     ack_n_o,
    output logic                arbiter_busy_o,
    output logic                bar1_wr_en_o,
    output logic [6:0]          bar1_addr_o,
    output logic [3:0]          bar1_wr_be_o,
    output logic [31:0]         bar1_wr_d_o,
    input  logic                bar1_wr_busy_i,
    output logic                timeout_err_o,
    output logic [1:0]          grant_id_o
);

    // One-hot state encoding.
    localparam logic [2:0] S_IDLE  = 3'b001;
    localparam logic [2:0] S_WRITE = 3'b010;
    localparam logic [2:0] S_HOLD  = 3'b100;

    logic [2:0]      state_q, state_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic            first_hold_q, first_hold_d;
    logic            wr_en_q, wr_en_d;
    logic [6:0]      addr_q, addr_d;
    logic [3:0]      be_q, be_d;
    logic [31:0]     data_q, data_d;
    logic [NREQ-1:0] ack_n_q, ack_n_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;
    logic [1:0]      grant_q, grant_d;

    logic            win_found;
    logic [1:0]      win_idx;
    logic [2:0]      cand;

    // Round-robin pick: first asserted request scanning from last grant + 1.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        cand      = 3'd0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = {1'b0, grant_q} + 3'(i);
            if (cand >= 3'(NREQ)) begin
                cand = cand - 3'(NREQ);
            end
            if (!win_found && wr_en_i[cand[1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[1:0];
            end
        end
    end

    // Next-state and next-output computation for the grant FSM.
    always_comb begin
        // NOTE: every _d starts from a default so no path through this block leaves a signal unassigned, which would infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        first_hold_d = first_hold_q;
        wr_en_d      = 1'b0;
        ack_n_d      = '1;
        busy_d       = busy_q;
        addr_d       = addr_q;
        be_d         = be_q;
        data_d       = data_q;
        err_d        = err_q;
        grant_d      = grant_q;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (win_found && !bar1_wr_busy_i) begin
                    state_d = S_WRITE;
                    wr_en_d = 1'b1;
                    ack_n_d = ~(NREQ'(1) << win_idx);
                    busy_d  = 1'b1;
                    addr_d  = addr_i[7*int'(win_idx) +: 7];
                    be_d    = be_i[4*int'(win_idx) +: 4];
                    data_d  = d_i[32*int'(win_idx) +: 32];
                    grant_d = win_idx;
                end
            end

            S_WRITE: begin
                state_d      = S_HOLD;
                cnt_d        = '0;
                first_hold_d = 1'b1;
                busy_d       = 1'b1;
            end

            S_HOLD: begin
                first_hold_d = 1'b0;
                // BAR1 raises busy one cycle after the strobe, so the first
                // HOLD cycle never looks at it.
                if (!first_hold_q) begin
                    if (!bar1_wr_busy_i) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end else if (cnt_q == TW'(TIMEOUT)) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        err_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: the reset is sampled only on the clock edge, and every register, output data included, returns to a defined value.
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            first_hold_q <= 1'b0;
            wr_en_q      <= 1'b0;
            addr_q       <= '0;
            be_q         <= '0;
            data_q       <= '0;
            ack_n_q      <= '1;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            grant_q      <= 2'(NREQ - 1);
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            first_hold_q <= first_hold_d;
            wr_en_q      <= wr_en_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            data_q       <= data_d;
            ack_n_q      <= ack_n_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            grant_q      <= grant_d;
        end
    end

    assign bar1_wr_en_o   = wr_en_q;
    assign bar1_addr_o    = addr_q;
    assign bar1_wr_be_o   = be_q;
    assign bar1_wr_d_o    = data_q;
    assign ack_n_o        = ack_n_q;
    assign arbiter_busy_o = busy_q;
    assign timeout_err_o  = err_q;
    assign grant_id_o     = grant_q;

endmodule

// File: doc/bar1_wr_arbiter.md
Name: bar1_wr_arbiter

Overview:
- Shares the single BAR1 register write port between NREQ write requesters: the BAR0 controller, the DMA completion path and the interrupt/response path.
- Arbitration is round-robin. The grant is held until BAR1 finishes its read-modify-write, signalled by `bar1_wr_busy_i`.
- Each requester sees a per-port active-low ack and a shared arbiter-busy flag.
- Sits between the requesters and the BAR1 write port.

Parameters:
- NREQ, 3, number of requesters; fixed at 3 for this revision.
- TIMEOUT, 255, maximum cycles `bar1_wr_busy_i` may stay high before the grant is abandoned.
- TW, 8, width of the timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- wr_en_i  in  3  per-requester write request, level, held until ack.
- addr_i  in  21  requester k address at [7k+6:7k].
- be_i  in  12  requester k byte enables at [4k+3:4k].
- d_i  in  96  requester k data at [32k+31:32k].
- ack_n_o  out  3  per-requester ack, active-low, one-cycle pulse.
- arbiter_busy_o  out  1  high whenever a grant is in progress.
- bar1_wr_en_o  out  1  one-cycle write strobe to BAR1.
- bar1_addr_o  out  7  BAR1 write address.
- bar1_wr_be_o  out  4  BAR1 byte enables.
- bar1_wr_d_o  out  32  BAR1 write data.
- bar1_wr_busy_i  in  1  BAR1 read-modify-write in progress.
- timeout_err_o  out  1  sticky, set when a BAR1 busy timeout occurs.
- grant_id_o  out  2  index of the last granted requester.

Behaviour:
- Reset values: clk and rst_n are the only clock and reset, sampled synchronously, active-low.
  - All outputs are registered.
  - On reset, mid-operation included: state=IDLE, bar1_wr_en_o=0, addr/be/d=0, ack_n_o=3'b111, arbiter_busy_o=0, timeout_err_o=0, grant_id_o=2 (last_grant=NREQ-1, so requester 0 wins first), timeout counter=0.
  - A reset during WRITE or HOLD issues no ack. The interrupted requester retries.
- States (one-hot): IDLE, WRITE, HOLD.
- IDLE:
  - If wr_en_i!=0 and bar1_wr_busy_i=0, pick the first asserted requester scanning from last_grant+1 modulo 3.
  - Latch that requester's addr, be and d into the output registers.
  - Set grant_id_o and last_grant to the winner. Go to WRITE.
  - With no request, or with bar1_wr_busy_i=1, stay in IDLE.
- WRITE (exactly 1 cycle):
  - bar1_wr_en_o=1; ack_n_o[g]=0 for the granted requester only; arbiter_busy_o=1.
  - Next state is HOLD. The timeout counter clears to 0.
- HOLD:
  - bar1_wr_en_o=0, ack_n_o=3'b111, arbiter_busy_o=1.
  - The first HOLD cycle is mandatory: BAR1 asserts busy one cycle after the strobe.
  - From the 2nd HOLD cycle onward: if bar1_wr_busy_i=0, go to IDLE.
  - Otherwise increment the counter. When counter==TIMEOUT, set timeout_err_o and go to IDLE.
- Latency: request sampled in IDLE at cycle n → strobe and ack in cycle n+1. Minimum 3 cycles per grant plus the BAR1 busy time.
- Requester rules:
  - addr/be/d must stay stable while wr_en_i is high.
  - wr_en_i drops the cycle after the ack. Requests seen in WRITE or HOLD are ignored, not queued.
- Simultaneous requests: served strictly in round-robin order. A requester that re-requests immediately cannot win twice while another is pending.
- bar1_wr_busy_i=1 in IDLE (external BAR1 activity) blocks new grants.
- arbiter_busy_o=0 only in IDLE.
- timeout_err_o clears only on reset.

Test Plan:
- Single request: wr_en_i=3'b001, addr=7'h10, be=4'hF, d=32'hDEADBEEF, busy high for 4 cycles after the strobe → one strobe with those values, ack_n_o=3'b110 for 1 cycle in the same cycle as the strobe, arbiter_busy_o high 6 cycles.
- Three simultaneous requests held continuously: wr_en_i=3'b111 → grant order 0,1,2,0; grant_id_o sequence 0,1,2,0; exactly one ack per grant.
- Byte enables: requester 2 with be=4'b0101, d=32'h11223344 → bar1_wr_be_o=4'h5, bar1_wr_d_o=32'h11223344, bar1_addr_o equals addr_i[20:14].
- Busy stuck high after the strobe → return to IDLE after TIMEOUT+2 HOLD cycles (257 with TIMEOUT=255: 1 mandatory cycle, 255 counting cycles, 1 terminal cycle). timeout_err_o=1 and stays 1; the next request is granted normally.
- bar1_wr_busy_i=1 while in IDLE with wr_en_i=3'b010 → no strobe until busy=0, then strobe the next cycle.
- rst_n=0 during HOLD → next cycle all outputs at reset values, ack_n_o=3'b111, requester 0 wins the next contention.
